result_accumulator: RTL and testbench
=====================================

RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 The block SHALL have parameter GRAB_SPACING, default 2: minimum cycles between consecutive grabResults pulses (legal range 2..15).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 32: width of expectedCount, resultsReceived and totalCount.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse that begins a collection run; honoured only in IDLE.
REQ-006 The block SHALL have port expectedCount  input  COUNT_WIDTH  number of results in the run; sampled on an honoured start.
REQ-007 The block SHALL have port resultsAvailable  input  1  the upstream show-ahead result FIFO is non-empty.
REQ-008 The block SHALL have port pcoeffSum  input  48  head-of-FIFO sum; valid while resultsAvailable=1.
REQ-009 The block SHALL have port pcoeffCount  input  13  head-of-FIFO count; valid while resultsAvailable=1.
REQ-010 The block SHALL have port eccStatus  input  1  ECC error indication; sampled on every grab.
REQ-011 The block SHALL have port grabResults  output  1  one-cycle pop of the upstream FIFO head.
REQ-012 The block SHALL have port busy  output  1  high in COLLECT and REPORT.
REQ-013 The block SHALL have port totalSum  output  64  accumulated pcoeffSum of the run.
REQ-014 The block SHALL have port totalCount  output  COUNT_WIDTH  accumulated pcoeffCount of the run.
REQ-015 The block SHALL have port resultsReceived  output  COUNT_WIDTH  results grabbed so far in the run.
REQ-016 The block SHALL have port eccErrorSeen  output  1  sticky; set if any grab sampled eccStatus=1.
REQ-017 The block SHALL have port resultValid  output  1  final totals available (REPORT state).
REQ-018 The block SHALL have port resultReady  input  1  consumer accepts the totals when resultValid=1.

Function
REQ-019 The FSM SHALL have states IDLE, COLLECT and REPORT.
REQ-020 IDLE + start with expectedCount>0 SHALL clear totalSum, totalCount, resultsReceived and eccErrorSeen, latch expectedCount, and go to COLLECT next cycle.
REQ-021 IDLE + start with expectedCount=0 SHALL clear the same registers and go directly to REPORT.
REQ-022 start SHALL be ignored in COLLECT and REPORT.
REQ-023 In COLLECT, grabResults SHALL be asserted combinationally-registered-free in a cycle iff resultsAvailable=1, the spacing counter has expired, and resultsReceived<latched expectedCount.
REQ-024 After any grab, the spacing counter SHALL block the next grab for GRAB_SPACING-1 cycles; the counter SHALL be expired on entry to COLLECT.
REQ-025 In a grab cycle, pcoeffSum, pcoeffCount and eccStatus SHALL be sampled; on the next edge, totalSum += zero-extended pcoeffSum, totalCount += zero-extended pcoeffCount, resultsReceived += 1, and eccErrorSeen |= eccStatus.
REQ-026 totalSum SHALL wrap modulo 2^64; totalCount and resultsReceived SHALL wrap modulo 2^COUNT_WIDTH; no saturation and no error flag.
REQ-027 A grab that makes resultsReceived equal the latched expectedCount SHALL move the FSM to REPORT on the same edge.
REQ-028 Results beyond expectedCount SHALL NOT be grabbed; they SHALL remain in the upstream FIFO.
REQ-029 In REPORT, resultValid SHALL be 1 and the totals SHALL be held stable; resultValid && resultReady SHALL return the FSM to IDLE on the next edge.
REQ-030 Totals and eccErrorSeen SHALL remain readable in IDLE until the next honoured start.
REQ-031 grabResults SHALL be 0 outside COLLECT.
REQ-032 resultsAvailable dropping mid-run SHALL stall the block in COLLECT without timeout.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, grabResults=0, busy=0, resultValid=0, totalSum=0, totalCount=0, resultsReceived=0, eccErrorSeen=0, spacing counter expired.
REQ-034 Reset mid-COLLECT or mid-REPORT SHALL abandon the run; FIFO contents are not touched.
REQ-035 The first honoured start SHALL be the first rising edge after rst deasserts at which start=1.

Verification
REQ-036 Start with expectedCount=3; FIFO holds sums 10, 20, 30 and counts 1, 2, 3 -> exactly 3 grabs each >=2 cycles apart; then resultValid=1, totalSum=60, totalCount=6, resultsReceived=3.
REQ-037 Start with expectedCount=0 -> REPORT next cycle, resultValid=1, all totals 0, no grabResults pulse.
REQ-038 Start with expectedCount=2; FIFO holds 4 entries -> exactly 2 grabs, 2 entries remain, and start is ignored while busy.
REQ-039 Two results each with pcoeffSum=48'hFFFF_FFFF_FFFF and the second with eccStatus=1 -> totalSum=64'h1_FFFF_FFFF_FFFE and eccErrorSeen=1.
REQ-040 Assert rst mid-COLLECT after 1 of 3 grabs -> all outputs 0 immediately; the next start with expectedCount=1 yields totalSum equal to the head entry only.
REQ-041 Hold resultReady=0 for 5 cycles in REPORT -> resultValid and totals stay stable; resultReady=1 -> IDLE next cycle.

Source files
------------

// File: rtl/result_accumulator.sv
// rtl/result_accumulator.sv - pops a run of per-block results from a show-ahead FIFO and totals them
module result_accumulator #(
    parameter int GRAB_SPACING = 2,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] expectedCount,
    input  logic                   resultsAvailable,
    input  logic [47:0]            pcoeffSum,
    input  logic [12:0]            pcoeffCount,
    input  logic                   eccStatus,
    output logic                   grabResults,
    output logic                   busy,
    output logic [63:0]            totalSum,
    output logic [COUNT_WIDTH-1:0] totalCount,
    output logic [COUNT_WIDTH-1:0] resultsReceived,
    output logic                   eccErrorSeen,
    output logic                   resultValid,
    input  logic                   resultReady
);

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    localparam logic [3:0] SPACE_RELOAD = 4'(GRAB_SPACING - 1);

    state_t                 state;
    logic [3:0]             spaceCnt;
    logic [COUNT_WIDTH-1:0] expectedLatched;
    logic [COUNT_WIDTH-1:0] receivedNext;

    assign receivedNext = resultsReceived + COUNT_WIDTH'(1);

    // The pop must land in the same cycle the head is consumed, so it is decoded
    // from registered state plus the live FIFO-not-empty flag.
    assign grabResults = (state == COLLECT) && resultsAvailable && (spaceCnt == 4'd0)
                         && (resultsReceived < expectedLatched);
    assign busy        = (state != IDLE);
    assign resultValid = (state == REPORT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            spaceCnt        <= 4'd0;
            expectedLatched <= '0;
            totalSum        <= 64'd0;
            totalCount      <= '0;
            resultsReceived <= '0;
            eccErrorSeen    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        totalSum        <= 64'd0;
                        totalCount      <= '0;
                        resultsReceived <= '0;
                        eccErrorSeen    <= 1'b0;
                        expectedLatched <= expectedCount;
                        spaceCnt        <= 4'd0;
                        state           <= (expectedCount == '0) ? REPORT : COLLECT;
                    end
                end
                COLLECT: begin
                    if (grabResults) begin
                        totalSum        <= totalSum + {16'd0, pcoeffSum};
                        totalCount      <= totalCount + COUNT_WIDTH'(pcoeffCount);
                        resultsReceived <= receivedNext;
                        eccErrorSeen    <= eccErrorSeen | eccStatus;
                        spaceCnt        <= SPACE_RELOAD;
                        if (receivedNext == expectedLatched) begin
                            state <= REPORT;
                        end
                    end else if (spaceCnt != 4'd0) begin
                        spaceCnt <= spaceCnt - 4'd1;
                    end
                end
                REPORT: begin
                    if (resultReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// tb/tb_result_accumulator.sv - randomized bench for result_accumulator against a FIFO/totals model
module tb_result_accumulator;
    localparam int GS = 2;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] expectedCount;
    logic          resultsAvailable;
    logic [47:0]   pcoeffSum;
    logic [12:0]   pcoeffCount;
    logic          eccStatus;
    logic          grabResults;
    logic          busy;
    logic [63:0]   totalSum;
    logic [CW-1:0] totalCount;
    logic [CW-1:0] resultsReceived;
    logic          eccErrorSeen;
    logic          resultValid;
    logic          resultReady;

    result_accumulator #(.GRAB_SPACING(GS), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .expectedCount(expectedCount),
        .resultsAvailable(resultsAvailable), .pcoeffSum(pcoeffSum), .pcoeffCount(pcoeffCount),
        .eccStatus(eccStatus), .grabResults(grabResults), .busy(busy), .totalSum(totalSum),
        .totalCount(totalCount), .resultsReceived(resultsReceived), .eccErrorSeen(eccErrorSeen),
        .resultValid(resultValid), .resultReady(resultReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] s;
        logic [12:0] c;
        logic        e;
    } ent_t;

    ent_t fifoQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cycleNum = 0;
    int   grabsSeen = 0;
    int   lastGrab = 0;
    int   badGrab = 0;
    bit   randGate = 0;

    // Upstream FIFO model: head is shown while non-empty, optionally gated to mimic stalls.
    task automatic drive_fifo();
        bit gateOn;
        gateOn = randGate ? ($urandom_range(0, 3) != 0) : 1'b1;
        resultsAvailable = (fifoQ.size() > 0) && gateOn;
        pcoeffSum   = (fifoQ.size() > 0) ? fifoQ[0].s : 48'd0;
        pcoeffCount = (fifoQ.size() > 0) ? fifoQ[0].c : 13'd0;
        eccStatus   = (fifoQ.size() > 0) ? fifoQ[0].e : 1'b0;
    endtask

    task automatic tick();
        bit grabbed;
        grabbed = 0;
        @(negedge clk);
        if (grabResults === 1'b1) begin
            if (!resultsAvailable || !busy || resultValid) badGrab++;
            if (grabsSeen > 0 && (cycleNum - lastGrab) < GS) badGrab++;
            grabbed = 1;
            lastGrab = cycleNum;
            grabsSeen++;
        end
        @(posedge clk);
        #1;
        cycleNum++;
        if (grabbed && fifoQ.size() > 0) void'(fifoQ.pop_front());
        drive_fifo();
    endtask

    task automatic push(input logic [47:0] s, input logic [12:0] c, input logic e);
        ent_t x;
        x.s = s; x.c = c; x.e = e;
        fifoQ.push_back(x);
        drive_fifo();
    endtask

    task automatic start_run(input int exp);
        grabsSeen = 0;
        badGrab = 0;
        expectedCount = CW'(exp);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n;
        n = 0;
        while (resultValid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (resultValid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: resultValid=%b required 1 after %0d cycles", name, resultValid, bound);
        end
    endtask

    task automatic ack();
        resultReady = 1'b1;
        tick();
        resultReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; expectedCount = 0; resultReady = 0;
        drive_fifo();
        tick(); tick();
        checks++;
        if ({grabResults, busy, resultValid, eccErrorSeen} !== 4'b0 || totalSum !== 64'd0 ||
            totalCount !== '0 || resultsReceived !== '0) begin
            errors++;
            $display("FAIL reset_state: grab=%b busy=%b valid=%b ecc=%b sum=%h cnt=%0d rcv=%0d required all 0",
                     grabResults, busy, resultValid, eccErrorSeen, totalSum, totalCount, resultsReceived);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        push(48'd10, 13'd1, 0); push(48'd20, 13'd2, 0); push(48'd30, 13'd3, 0);
        start_run(3);
        wait_valid(40, "basic");
        checks++;
        if (totalSum !== 64'd60 || totalCount !== CW'(6) || resultsReceived !== CW'(3) || eccErrorSeen !== 1'b0) begin
            errors++;
            $display("FAIL basic_totals: sum=%0d cnt=%0d rcv=%0d ecc=%b required 60 6 3 0",
                     totalSum, totalCount, resultsReceived, eccErrorSeen);
        end
        checks++;
        if (grabsSeen != 3 || badGrab != 0 || fifoQ.size() != 0) begin
            errors++;
            $display("FAIL basic_grabs: grabs=%0d bad=%0d left=%0d required 3 0 0", grabsSeen, badGrab, fifoQ.size());
        end
    endtask

    task automatic test_hold();
        logic [63:0]   s0;
        logic [CW-1:0] c0;
        int            bad;
        s0 = totalSum; c0 = totalCount; bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resultValid !== 1'b1 || totalSum !== s0 || totalCount !== c0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: unstable cycles=%0d required 0", bad);
        end
        ack();
        checks++;
        if (busy !== 1'b0 || resultValid !== 1'b0 || totalSum !== s0) begin
            errors++;
            $display("FAIL hold_release: busy=%b valid=%b sum=%0d required 0 0 %0d", busy, resultValid, totalSum, s0);
        end
    endtask

    task automatic test_zero();
        push(48'd77, 13'd7, 1);
        start_run(0);
        checks++;
        if (resultValid !== 1'b1 || totalSum !== 64'd0 || totalCount !== '0 || resultsReceived !== '0 || eccErrorSeen !== 0) begin
            errors++;
            $display("FAIL zero_run: valid=%b sum=%0d cnt=%0d rcv=%0d ecc=%b required 1 0 0 0 0",
                     resultValid, totalSum, totalCount, resultsReceived, eccErrorSeen);
        end
        tick(); tick();
        checks++;
        if (grabsSeen != 0 || fifoQ.size() != 1) begin
            errors++;
            $display("FAIL zero_nograb: grabs=%0d left=%0d required 0 1", grabsSeen, fifoQ.size());
        end
        ack();
        fifoQ.delete();
        drive_fifo();
    endtask

    task automatic test_limit();
        for (int i = 0; i < 4; i++) push(48'(100 + i), 13'(i + 1), 0);
        start_run(2);
        expectedCount = CW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(40, "limit");
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (grabsSeen != 2 || fifoQ.size() != 2 || resultsReceived !== CW'(2) || totalSum !== 64'd201 || badGrab != 0) begin
            errors++;
            $display("FAIL limit: grabs=%0d left=%0d rcv=%0d sum=%0d bad=%0d required 2 2 2 201 0",
                     grabsSeen, fifoQ.size(), resultsReceived, totalSum, badGrab);
        end
        ack();
        fifoQ.delete();
        drive_fifo();
    endtask

    task automatic test_wrap_ecc();
        push(48'hFFFF_FFFF_FFFF, 13'h1FFF, 0);
        push(48'hFFFF_FFFF_FFFF, 13'h1FFF, 1);
        start_run(2);
        wait_valid(40, "wrap");
        checks++;
        if (totalSum !== 64'h1_FFFF_FFFF_FFFE || eccErrorSeen !== 1'b1 || totalCount !== CW'(16382)) begin
            errors++;
            $display("FAIL wrap_ecc: sum=%h ecc=%b cnt=%0d required 1fffffffffffe 1 16382", totalSum, eccErrorSeen, totalCount);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int n;
        push(48'd10, 13'd1, 1); push(48'd20, 13'd2, 0); push(48'd30, 13'd3, 0);
        start_run(3);
        n = 0;
        while (grabsSeen < 1 && n < 20) begin tick(); n++; end
        rst = 1'b1;
        #1;
        checks++;
        if ({grabResults, busy, resultValid, eccErrorSeen} !== 4'b0 || totalSum !== 64'd0 ||
            totalCount !== '0 || resultsReceived !== '0) begin
            errors++;
            $display("FAIL reset_mid: grab=%b busy=%b valid=%b ecc=%b sum=%0d rcv=%0d required all 0",
                     grabResults, busy, resultValid, eccErrorSeen, totalSum, resultsReceived);
        end
        tick();
        rst = 1'b0;
        tick();
        start_run(1);
        wait_valid(20, "reset_restart");
        checks++;
        if (totalSum !== 64'd20 || fifoQ.size() != 1 || eccErrorSeen !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: sum=%0d left=%0d ecc=%b required 20 1 0", totalSum, fifoQ.size(), eccErrorSeen);
        end
        ack();
        fifoQ.delete();
        drive_fifo();
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int          exp, extra;
            logic [63:0] refSum;
            logic [CW-1:0] refCnt;
            bit          refEcc;
            exp = $urandom_range(1, 6);
            extra = $urandom_range(0, 2);
            refSum = 0; refCnt = 0; refEcc = 0;
            for (int i = 0; i < exp + extra; i++) begin
                ent_t x;
                x.s = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
                x.c = 13'($urandom);
                x.e = ($urandom_range(0, 7) == 0);
                if (i < exp) begin
                    refSum = refSum + 64'(x.s);
                    refCnt = refCnt + CW'(x.c);
                    refEcc = refEcc | x.e;
                end
                fifoQ.push_back(x);
            end
            randGate = 1;
            drive_fifo();
            start_run(exp);
            wait_valid(200, "random");
            checks++;
            if (totalSum !== refSum || totalCount !== refCnt || eccErrorSeen !== refEcc ||
                resultsReceived !== CW'(exp) || grabsSeen != exp || fifoQ.size() != extra || badGrab != 0) begin
                errors++;
                $display("FAIL random_run%0d: sum=%h/%h cnt=%0d/%0d ecc=%b/%b rcv=%0d/%0d grabs=%0d left=%0d/%0d bad=%0d",
                         r, totalSum, refSum, totalCount, refCnt, eccErrorSeen, refEcc,
                         resultsReceived, exp, grabsSeen, fifoQ.size(), extra, badGrab);
            end
            randGate = 0;
            ack();
            fifoQ.delete();
            drive_fifo();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_zero();
        test_limit();
        test_wrap_ecc();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
